// File: rtl/k007232_pkg.sv
// -----------------------------------------------------------------------------
// k007232_pkg
// Shared definitions for the K007232 voice sequencer:
//   - chip register index constants
//   - FSM state enumeration
//   - request record carried through the request FIFO
//   - wr_entry(): maps a write index to the {register, data} pair for it
// Optional build macro: K007232_VOICE_SEQ_VOL_EN adds the volume nibble to the
// request and a register-13 (level) write before the trigger.
// -----------------------------------------------------------------------------
package k007232_pkg;

  localparam logic [3:0] REG_A_BASE = 4'd0;
  localparam logic [3:0] REG_B_BASE = 4'd6;
  localparam logic [3:0] REG_LOOP   = 4'd12;
  localparam logic [3:0] REG_SLEV   = 4'd13;
  localparam logic [3:0] OFS_TRIG   = 4'd4;

`ifdef K007232_VOICE_SEQ_VOL_EN
  // Eight writes per request: indices 0..7
  localparam logic [2:0] LAST_WR_IDX = 3'd7;
`else
  // Seven writes per request: indices 0..6
  localparam logic [2:0] LAST_WR_IDX = 3'd6;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic        ch;
    logic [1:0]  mode;
    logic [11:0] pitch;
    logic [16:0] addr;
    logic        loop;
`ifdef K007232_VOICE_SEQ_VOL_EN
    logic [3:0]  vol;
`endif
  } req_t;

  // Register/data pair for write number idx of a request; the trigger write
  // is always the last one so the chip starts playback with every other
  // parameter already in place.
`ifdef K007232_VOICE_SEQ_VOL_EN
  function automatic logic [11:0] wr_entry(input logic [2:0] idx, input req_t req,
                                           input logic [1:0] loop_sh, input logic [7:0] vol_sh);
`else
  function automatic logic [11:0] wr_entry(input logic [2:0] idx, input req_t req,
                                           input logic [1:0] loop_sh);
`endif
    logic [3:0]  base;
    logic [11:0] ent;
    base = req.ch ? REG_B_BASE : REG_A_BASE;
    case (idx)
      3'd0:    ent = {base,            2'b00, req.mode, req.pitch[11:8]};
      3'd1:    ent = {base + 4'd1,     req.pitch[7:0]};
      3'd2:    ent = {base + 4'd3,     req.addr[7:0]};
      3'd3:    ent = {base + 4'd2,     req.addr[15:8]};
      3'd4:    ent = {base + 4'd5,     7'b0000000, req.addr[16]};
      3'd5:    ent = {REG_LOOP,        6'b000000, loop_sh};
`ifdef K007232_VOICE_SEQ_VOL_EN
      3'd6:    ent = {REG_SLEV,        vol_sh};
      3'd7:    ent = {base + OFS_TRIG, 8'h00};
`else
      3'd6:    ent = {base + OFS_TRIG, 8'h00};
`endif
      default: ent = 12'h000;
    endcase
    return ent;
  endfunction

endpackage

// File: rtl/k007232_req_fifo.sv
// -----------------------------------------------------------------------------
// k007232_req_fifo
// Synchronous request FIFO, DEPTH entries of WIDTH bits (DEPTH power of two).
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_push  : push request; accepted only while o_ready is high
//   i_pop   : pop request; ignored while empty
//   i_data  : entry written on an accepted push
//   o_data  : head entry (valid while !o_empty)
//   o_ready : registered, high while count < DEPTH
//   o_empty : count == 0
//   o_cnt   : registered entry count
// -----------------------------------------------------------------------------
module k007232_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_ready,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  // Ready is the registered flag, so a push on a full FIFO is refused even if
  // a pop happens on the same edge.
  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_cnt != {CW{1'b0}});

  // Next entry count; push and pop together cancel out
  always_comb begin
    w_cnt_nx = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nx = r_cnt + CW'(1'b1);
      2'b01:   w_cnt_nx = r_cnt - CW'(1'b1);
      default: w_cnt_nx = r_cnt;
    endcase
  end

  // Pointers, count and ready flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
      end
      r_cnt   <= w_cnt_nx;
      r_ready <= (w_cnt_nx < CW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_empty = (r_cnt == {CW{1'b0}});
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/k007232_voice_seq.sv
// -----------------------------------------------------------------------------
// k007232_voice_seq
// Queues voice-start requests and replays each one as a burst of K007232
// register writes (SETUP / STROBE / HOLD per write, one phase per i_PCEN tick),
// finishing with the channel's trigger write.
// Ports:
//   i_EMUCLK           master clock
//   i_RST              async active-high reset, aborts any sequence
//   i_PCEN             tick enable for FSM, pops and bus outputs
//   i_REQ_VALID/o_REQ_READY, i_REQ_CH/MODE/PITCH/ADDR/LOOP  request push
//   i_REQ_VOL          (K007232_VOICE_SEQ_VOL_EN only) 4-bit channel level
//   o_AB, o_DB, o_DACS_n  chip register bus (registered)
//   o_BUSY             high outside IDLE
//   o_FIFO_CNT         queued request count
//   o_DONE, o_DONE_CH  one-clock pulse at end of trigger write + channel
// Build macro: K007232_VOICE_SEQ_VOL_EN (volume port, level shadow, reg-13 write).
// -----------------------------------------------------------------------------
module k007232_voice_seq
  import k007232_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_RST,
  input  logic                        i_PCEN,
  input  logic                        i_REQ_VALID,
  output logic                        o_REQ_READY,
  input  logic                        i_REQ_CH,
  input  logic [1:0]                  i_REQ_MODE,
  input  logic [11:0]                 i_REQ_PITCH,
  input  logic [16:0]                 i_REQ_ADDR,
  input  logic                        i_REQ_LOOP,
`ifdef K007232_VOICE_SEQ_VOL_EN
  input  logic [3:0]                  i_REQ_VOL,
`endif
  output logic [3:0]                  o_AB,
  output logic [7:0]                  o_DB,
  output logic                        o_DACS_n,
  output logic                        o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_CNT,
  output logic                        o_DONE,
  output logic                        o_DONE_CH
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  req_t                   w_push_req;
  req_t                   w_head;
  req_t                   w_req_nx;
  req_t                   r_req;
  logic [$bits(req_t)-1:0] w_fifo_rdata;
  logic                   w_fifo_empty;
  logic                   w_fifo_ready;
  logic [CW-1:0]          w_fifo_cnt;
  logic                   w_pop;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [2:0]             r_idx;
  logic [2:0]             w_idx_nx;
  logic [1:0]             r_loop;
  logic [1:0]             w_loop_nx;
`ifdef K007232_VOICE_SEQ_VOL_EN
  logic [7:0]             r_vol;
  logic [7:0]             w_vol_nx;
`endif
  logic                   w_last;
  logic                   w_enter_setup;
  logic [11:0]            w_ent;

  logic [3:0]             r_ab;
  logic [3:0]             w_ab_nx;
  logic [7:0]             r_db;
  logic [7:0]             w_db_nx;
  logic                   r_dacs_n;
  logic                   w_dacs_n_nx;
  logic                   r_done;
  logic                   w_done_nx;
  logic                   r_done_ch;
  logic                   w_done_ch_nx;
  logic                   r_busy;

  assign w_push_req.ch    = i_REQ_CH;
  assign w_push_req.mode  = i_REQ_MODE;
  assign w_push_req.pitch = i_REQ_PITCH;
  assign w_push_req.addr  = i_REQ_ADDR;
  assign w_push_req.loop  = i_REQ_LOOP;
`ifdef K007232_VOICE_SEQ_VOL_EN
  assign w_push_req.vol   = i_REQ_VOL;
`endif

  k007232_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .i_clk   (i_EMUCLK),
    .i_rst   (i_RST),
    .i_push  (i_REQ_VALID),
    .i_pop   (w_pop),
    .i_data  (w_push_req),
    .o_data  (w_fifo_rdata),
    .o_ready (w_fifo_ready),
    .o_empty (w_fifo_empty),
    .o_cnt   (w_fifo_cnt)
  );

  assign w_head = req_t'(w_fifo_rdata);
  assign w_pop  = i_PCEN && (r_state == ST_POP);
  assign w_last = (r_idx == LAST_WR_IDX);

  // FSM state register
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state; every transition waits for a tick
  always_comb begin
    w_state_nx = r_state;
    if (i_PCEN) begin
      case (r_state)
        ST_IDLE:   w_state_nx = w_fifo_empty ? ST_IDLE : ST_POP;
        ST_POP:    w_state_nx = ST_SETUP;
        ST_SETUP:  w_state_nx = ST_STROBE;
        ST_STROBE: w_state_nx = ST_HOLD;
        ST_HOLD:   w_state_nx = w_last ? ST_DONE : ST_SETUP;
        ST_DONE:   w_state_nx = ST_IDLE;
        default:   w_state_nx = ST_IDLE;
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Next request latch, write index and shadows. The shadows update in POP so
  // the loop (and level) writes of this very sequence already carry the new bit.
  always_comb begin
    w_req_nx  = w_pop ? w_head : r_req;
    w_idx_nx  = r_idx;
    w_loop_nx = r_loop;
`ifdef K007232_VOICE_SEQ_VOL_EN
    w_vol_nx  = r_vol;
`endif
    if (w_pop) begin
      w_idx_nx = 3'd0;
      if (w_req_nx.ch) begin
        w_loop_nx[1] = w_req_nx.loop;
`ifdef K007232_VOICE_SEQ_VOL_EN
        w_vol_nx[3:0] = w_req_nx.vol;
`endif
      end else begin
        w_loop_nx[0] = w_req_nx.loop;
`ifdef K007232_VOICE_SEQ_VOL_EN
        w_vol_nx[7:4] = w_req_nx.vol;
`endif
      end
    end else if (i_PCEN && (r_state == ST_HOLD) && !w_last) begin
      w_idx_nx = r_idx + 3'd1;
    end else begin
      w_idx_nx = r_idx;
    end
  end

  // Request latch, write index and shadow registers
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_req  <= '0;
      r_idx  <= 3'd0;
      r_loop <= 2'b00;
`ifdef K007232_VOICE_SEQ_VOL_EN
      r_vol  <= 8'h00;
`endif
    end else begin
      r_req  <= w_req_nx;
      r_idx  <= w_idx_nx;
      r_loop <= w_loop_nx;
`ifdef K007232_VOICE_SEQ_VOL_EN
      r_vol  <= w_vol_nx;
`endif
    end
  end

  // FSM outputs: bus values are computed for the state being entered so the
  // registered bus lines up with the registered state.
  always_comb begin
`ifdef K007232_VOICE_SEQ_VOL_EN
    w_ent = wr_entry(w_idx_nx, w_req_nx, w_loop_nx, w_vol_nx);
`else
    w_ent = wr_entry(w_idx_nx, w_req_nx, w_loop_nx);
`endif
    w_enter_setup = i_PCEN && ((r_state == ST_POP) || ((r_state == ST_HOLD) && !w_last));
    if (w_enter_setup) begin
      w_ab_nx = w_ent[11:8];
      w_db_nx = w_ent[7:0];
    end else begin
      w_ab_nx = r_ab;
      w_db_nx = r_db;
    end
    w_dacs_n_nx = (w_state_nx != ST_STROBE);
    w_done_nx   = i_PCEN && (r_state == ST_HOLD) && w_last;
    if (w_done_nx) begin
      w_done_ch_nx = r_req.ch;
    end else begin
      w_done_ch_nx = r_done_ch;
    end
  end

  // Output registers
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_ab      <= 4'd0;
      r_db      <= 8'd0;
      r_dacs_n  <= 1'b1;
      r_done    <= 1'b0;
      r_done_ch <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ab      <= w_ab_nx;
      r_db      <= w_db_nx;
      r_dacs_n  <= w_dacs_n_nx;
      r_done    <= w_done_nx;
      r_done_ch <= w_done_ch_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  assign o_AB        = r_ab;
  assign o_DB        = r_db;
  assign o_DACS_n    = r_dacs_n;
  assign o_DONE      = r_done;
  assign o_DONE_CH   = r_done_ch;
  assign o_BUSY      = r_busy;
  assign o_REQ_READY = w_fifo_ready;
  assign o_FIFO_CNT  = w_fifo_cnt;

endmodule

// File: tb/tb_k007232_voice_seq.sv
// -----------------------------------------------------------------------------
// tb_k007232_voice_seq
// Table of requests with hand-computed register write sequences, plus hand
// sequences for back-pressure, reset mid-strobe, slow tick rate and (when
// K007232_VOICE_SEQ_VOL_EN is defined) the level write.
// -----------------------------------------------------------------------------
module tb_k007232_voice_seq;

`ifdef K007232_VOICE_SEQ_VOL_EN
  localparam int NW = 8;
`else
  localparam int NW = 7;
`endif
  localparam int LAT = 2 + 3 * NW;

  logic        clk = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_PCEN = 1'b1;
  logic        i_REQ_VALID = 1'b0;
  logic        i_REQ_CH = 1'b0;
  logic [1:0]  i_REQ_MODE = 2'd0;
  logic [11:0] i_REQ_PITCH = 12'd0;
  logic [16:0] i_REQ_ADDR = 17'd0;
  logic        i_REQ_LOOP = 1'b0;
`ifdef K007232_VOICE_SEQ_VOL_EN
  logic [3:0]  i_REQ_VOL = 4'd0;
`endif
  logic        o_REQ_READY;
  logic [3:0]  o_AB;
  logic [7:0]  o_DB;
  logic        o_DACS_n;
  logic        o_BUSY;
  logic [2:0]  o_FIFO_CNT;
  logic        o_DONE;
  logic        o_DONE_CH;

  always #5 clk = ~clk;

  k007232_voice_seq #(.FIFO_DEPTH(4)) dut (
    .i_EMUCLK    (clk),
    .i_RST       (i_RST),
    .i_PCEN      (i_PCEN),
    .i_REQ_VALID (i_REQ_VALID),
    .o_REQ_READY (o_REQ_READY),
    .i_REQ_CH    (i_REQ_CH),
    .i_REQ_MODE  (i_REQ_MODE),
    .i_REQ_PITCH (i_REQ_PITCH),
    .i_REQ_ADDR  (i_REQ_ADDR),
    .i_REQ_LOOP  (i_REQ_LOOP),
`ifdef K007232_VOICE_SEQ_VOL_EN
    .i_REQ_VOL   (i_REQ_VOL),
`endif
    .o_AB        (o_AB),
    .o_DB        (o_DB),
    .o_DACS_n    (o_DACS_n),
    .o_BUSY      (o_BUSY),
    .o_FIFO_CNT  (o_FIFO_CNT),
    .o_DONE      (o_DONE),
    .o_DONE_CH   (o_DONE_CH)
  );

  typedef struct {
    logic        ch;
    logic [1:0]  mode;
    logic [11:0] pitch;
    logic [16:0] addr;
    logic        loop;
    logic [3:0]  vol;
    logic [7:0]  slev;
    logic [11:0] wr [7];   // {AB, DB}, level write excluded
  } vec_t;

  vec_t tv [5];

  int checks = 0;
  int errors = 0;

  // bus monitor
  logic [11:0] wr_q [$];
  int          slen_q [$];
  int          dcyc_q [$];
  logic        dch_q [$];
  int          cyc = 0;
  logic        prev_dacs = 1'b1;
  int          cur_len = 0;
  logic        pcen_div = 1'b0;
  int          pcen_ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!o_DACS_n) begin
      if (prev_dacs) begin
        wr_q.push_back({o_AB, o_DB});
        cur_len = 1;
      end else begin
        cur_len++;
      end
    end else if (!prev_dacs) begin
      slen_q.push_back(cur_len);
    end
    prev_dacs = o_DACS_n;
    if (o_DONE) begin
      dcyc_q.push_back(cyc);
      dch_q.push_back(o_DONE_CH);
    end
  end

  // tick enable: always high, or one clock in three
  initial begin
    forever begin
      @(negedge clk);
      if (pcen_div) begin
        pcen_ph = (pcen_ph == 2) ? 0 : pcen_ph + 1;
        i_PCEN  = (pcen_ph == 0);
      end else begin
        i_PCEN = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] get_wr(input int idx);
    return (idx < wr_q.size()) ? wr_q[idx] : 12'hEEE;
  endfunction

  function automatic int get_slen(input int idx);
    return (idx < slen_q.size()) ? slen_q[idx] : -1;
  endfunction

  function automatic int get_dcyc(input int idx);
    return (idx < dcyc_q.size()) ? dcyc_q[idx] : -1;
  endfunction

  function automatic logic get_dch(input int idx);
    return (idx < dch_q.size()) ? dch_q[idx] : 1'bx;
  endfunction

  function automatic logic [11:0] exp_wr(input int v, input int k);
`ifdef K007232_VOICE_SEQ_VOL_EN
    if (k < 6) return tv[v].wr[k];
    if (k == 6) return {4'd13, tv[v].slev};
    return tv[v].wr[6];
`else
    return tv[v].wr[k];
`endif
  endfunction

  // Call at a negedge or #1 after a posedge; returns the cycle of the push edge.
  task automatic push_req(input int v, output int pcyc);
    int n;
    i_REQ_CH    = tv[v].ch;
    i_REQ_MODE  = tv[v].mode;
    i_REQ_PITCH = tv[v].pitch;
    i_REQ_ADDR  = tv[v].addr;
    i_REQ_LOOP  = tv[v].loop;
`ifdef K007232_VOICE_SEQ_VOL_EN
    i_REQ_VOL   = tv[v].vol;
`endif
    n = 0;
    while (!o_REQ_READY && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_wait", o_REQ_READY, 1'b1);
    i_REQ_VALID = o_REQ_READY;
    @(posedge clk);
    #1;
    pcyc = cyc;
    i_REQ_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (dcyc_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", (dcyc_q.size() >= target), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_RST = 1'b1;
    repeat (2) @(negedge clk);
    i_RST = 1'b0;
    @(negedge clk);
  endtask

  // One request start to finish, compared against its table row.
  task automatic run_vec(input int v, input int slen_exp, input bit do_lat);
    int b, sb, d, pc;
    b  = wr_q.size();
    sb = slen_q.size();
    d  = dcyc_q.size();
    @(negedge clk);
    push_req(v, pc);
    wait_done(d + 1, 400);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_nwr", v), wr_q.size() - b, NW);
    for (int k = 0; k < NW; k++) begin
      chk($sformatf("v%0d_wr%0d", v, k), get_wr(b + k), exp_wr(v, k));
      chk($sformatf("v%0d_strobe%0d", v, k), get_slen(sb + k), slen_exp);
    end
    chk($sformatf("v%0d_done_ch", v), get_dch(d), tv[v].ch);
    chk($sformatf("v%0d_done_cnt", v), dcyc_q.size() - d, 1);
    chk($sformatf("v%0d_idle", v), o_BUSY, 1'b0);
    if (do_lat) begin
      chk($sformatf("v%0d_latency", v), get_dcyc(d) - pc, LAT);
    end
  endtask

  initial begin
    int bp_v [6];
    int pc, pc5, b, d, n, ntrig;

    tv[0] = '{1'b0, 2'd2, 12'hABC, 17'h12345, 1'b1, 4'h5, 8'h50,
              '{12'h02A, 12'h1BC, 12'h345, 12'h223, 12'h501, 12'hC01, 12'h400}};
    tv[1] = '{1'b1, 2'd1, 12'h123, 17'h0FEDC, 1'b0, 4'h7, 8'h57,
              '{12'h611, 12'h723, 12'h9DC, 12'h8FE, 12'hB00, 12'hC01, 12'hA00}};
    tv[2] = '{1'b1, 2'd3, 12'hFFF, 17'h1FFFF, 1'b1, 4'h2, 8'h52,
              '{12'h63F, 12'h7FF, 12'h9FF, 12'h8FF, 12'hB01, 12'hC03, 12'hA00}};
    tv[3] = '{1'b0, 2'd0, 12'h000, 17'h00000, 1'b0, 4'hC, 8'hC2,
              '{12'h000, 12'h100, 12'h300, 12'h200, 12'h500, 12'hC02, 12'h400}};
    tv[4] = '{1'b1, 2'd0, 12'h000, 17'h00000, 1'b0, 4'h7, 8'h07,
              '{12'h600, 12'h700, 12'h900, 12'h800, 12'hB00, 12'hC00, 12'hA00}};
    bp_v = '{0, 1, 2, 3, 0, 1};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dacs_n", o_DACS_n, 1'b1);
    chk("rst_ab", o_AB, 4'd0);
    chk("rst_db", o_DB, 8'd0);
    chk("rst_busy", o_BUSY, 1'b0);
    chk("rst_done", o_DONE, 1'b0);
    chk("rst_done_ch", o_DONE_CH, 1'b0);
    chk("rst_cnt", o_FIFO_CNT, 3'd0);
    chk("rst_ready", o_REQ_READY, 1'b1);
    @(negedge clk);
    i_RST = 1'b0;
    repeat (2) @(negedge clk);

    // table: loop shadow carries across rows (A=1, then B=0, B=1, A=0)
    for (int i = 0; i < 4; i++) begin
      run_vec(i, 1, (i == 0));
    end

    // back-pressure: one in flight, four queued, fifth waits for a pop
    b = wr_q.size();
    d = dcyc_q.size();
    @(negedge clk);
    push_req(bp_v[0], pc);
    n = 0;
    while (!(o_BUSY && o_FIFO_CNT == 3'd0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_popped", (o_BUSY && o_FIFO_CNT == 3'd0), 1'b1);
    for (int j = 1; j < 5; j++) begin
      push_req(bp_v[j], pc);
    end
    chk("bp_cnt_full", o_FIFO_CNT, 3'd4);
    chk("bp_ready_low", o_REQ_READY, 1'b0);
    push_req(bp_v[5], pc5);
    chk("bp_fifth_after_done", (pc5 > get_dcyc(d)) && (get_dcyc(d) > 0), 1'b1);
    wait_done(d + 6, 6 * 40);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("bp_seq%0d_first", s), get_wr(b + s * NW), tv[bp_v[s]].wr[0]);
      chk($sformatf("bp_seq%0d_trig", s), get_wr(b + s * NW + NW - 1), tv[bp_v[s]].wr[6]);
      chk($sformatf("bp_seq%0d_done_ch", s), get_dch(d + s), tv[bp_v[s]].ch);
    end
    chk("bp_total_writes", wr_q.size() - b, 6 * NW);

    // reset during the strobe of the address-3 write, second request queued
    b = wr_q.size();
    d = dcyc_q.size();
    @(negedge clk);
    push_req(0, pc);
    push_req(1, pc);
    n = 0;
    @(negedge clk);
    while (!(!o_DACS_n && o_AB == 4'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_found_strobe", (!o_DACS_n && o_AB == 4'd3), 1'b1);
    chk("abort_cnt_before", o_FIFO_CNT, 3'd1);
    i_RST = 1'b1;
    #1;
    chk("abort_dacs_n", o_DACS_n, 1'b1);
    chk("abort_cnt", o_FIFO_CNT, 3'd0);
    chk("abort_busy", o_BUSY, 1'b0);
    chk("abort_ab", o_AB, 4'd0);
    chk("abort_db", o_DB, 8'd0);
    chk("abort_ready", o_REQ_READY, 1'b1);
    @(negedge clk);
    i_RST = 1'b0;
    repeat (80) @(negedge clk);
    ntrig = 0;
    for (int k = b; k < wr_q.size(); k++) begin
      if (wr_q[k][11:8] == 4'd4 || wr_q[k][11:8] == 4'd10) ntrig++;
    end
    chk("abort_no_trigger", ntrig, 0);
    chk("abort_writes", wr_q.size() - b, 3);
    chk("abort_no_done", dcyc_q.size() - d, 0);
    chk("abort_idle_cnt", o_FIFO_CNT, 3'd0);

`ifdef K007232_VOICE_SEQ_VOL_EN
    // level write for channel B from a cleared shadow
    do_reset();
    run_vec(4, 1, 1'b1);
`endif

    // slow tick: every phase stretched to three clocks
    do_reset();
    pcen_div = 1'b1;
    run_vec(0, 3, 1'b0);
    pcen_div = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/k007232_voice_seq.md
K007232_VOICE_SEQ -- requirements
Module: k007232_voice_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue depth; power of two, 2..16.
REQ-002 i_EMUCLK  in  1  master clock; all state on rising edge.
REQ-003 i_RST  in  1  reset, asynchronous, active-high.
REQ-004 i_PCEN  in  1  tick enable; FSM and bus outputs advance only when high.
REQ-005 i_REQ_VALID / o_REQ_READY  in/out  1  request handshake; a push occurs when both are high on a rising edge.
REQ-006 i_REQ_CH  in  1  target channel: 0 = A, 1 = B.
REQ-007 i_REQ_MODE  in  2  mode bits, written to reg[5:4].
REQ-008 i_REQ_PITCH  in  12  prescaler reload value.
REQ-009 i_REQ_ADDR  in  17  sample start address.
REQ-010 i_REQ_LOOP  in  1  loop enable for the target channel.
REQ-011 o_AB  out  4  chip register address.
REQ-012 o_DB  out  8  chip write data.
REQ-013 o_DACS_n  out  1  chip register strobe, active-low.
REQ-014 o_BUSY  out  1  high while a sequence is in flight.
REQ-015 o_FIFO_CNT  out  clog2(FIFO_DEPTH)+1  queued request count.
REQ-016 o_DONE / o_DONE_CH  out  1/1  one-mclk pulse when a trigger write ends, plus the channel it served.

Function
REQ-017 FIFO push on handshake; o_REQ_READY = (count < FIFO_DEPTH), driven from the registered count only.
REQ-018 Simultaneous push and pop leaves the count unchanged; on a full FIFO, a push is accepted only if READY was high on that edge.
REQ-019 FSM states: IDLE, POP, SETUP, STROBE, HOLD, DONE; each transition consumes one i_PCEN tick.
REQ-020 IDLE -> POP when FIFO is non-empty; POP latches the head entry, increments the read pointer, and clears the write index.
REQ-021 SETUP drives o_AB/o_DB with DACS_n=1; STROBE drives DACS_n=0; HOLD restores DACS_n=1 and keeps AB/DB stable.
REQ-022 HOLD -> SETUP with the next index; after the last index, HOLD -> DONE -> IDLE.
REQ-023 Write order, with base b = CH ? 6 : 0:
  - (b+0, {00,MODE,PITCH[11:8]})
  - (b+1, PITCH[7:0])
  - (b+3, ADDR[7:0])
  - (b+2, ADDR[15:8])
  - (b+5, {0000000,ADDR[16]})
  - (12, {000000,loopB,loopA})
  - (b+4, 0x00) trigger, always last.
REQ-024 A 2-bit loop shadow is updated in POP with the request's bit; the other channel's bit is preserved.
REQ-025 Latency: each write takes 3 ticks; a 7-write sequence gives 21 ticks plus POP and DONE, so 23 ticks from IDLE to DONE.
REQ-026 o_DONE pulses for one mclk cycle in DONE, gated by i_PCEN.
REQ-027 Requests execute strictly in FIFO order; same-channel requests are neither merged nor dropped.
REQ-028 i_PCEN low freezes the FSM, FIFO pops and bus outputs; pushes are still accepted.
REQ-029 o_BUSY is high in every state except IDLE.

Reset
REQ-030 i_RST asserted at any time, including mid-STROBE, immediately forces the following and aborts the in-flight request:
  - o_DACS_n=1, o_AB=0, o_DB=0
  - FSM=IDLE, FIFO empty, o_REQ_READY=1
  - o_BUSY=0, o_DONE=0, o_DONE_CH=0, o_FIFO_CNT=0
  - loop shadow=00

Configuration
REQ-031 Macro K007232_VOICE_SEQ_VOL_EN, when defined, adds:
  - port i_REQ_VOL[3:0];
  - an 8-bit volume shadow, A in [7:4], B in [3:0];
  - write (13, shadow), inserted after the regC write and before the trigger, giving 8 writes and 26 ticks.
REQ-032 Without the macro, no volume port or shadow exists and register 13 is never addressed.

Structure
REQ-033 Shared package k007232_pkg holds:
  - register index constants (REG_A_BASE=0, REG_B_BASE=6, REG_LOOP=12, REG_SLEV=13, OFS_TRIG=4);
  - the FSM state enum;
  - the request struct typedef.
REQ-034 One sub-module, k007232_req_fifo (parameterised synchronous FIFO); the FSM, shadows and bus drive live in the top.

Verification
REQ-035 Channel A request, PCEN always high, PITCH=0xABC, MODE=2, ADDR=0x1_2345, LOOP=1 -> writes (0,0x2A), (1,0xBC), (3,0x45), (2,0x23), (5,0x01), (12,0x01), (4,0x00); DONE at tick 23 with DONE_CH=0.
REQ-036 Channel A with LOOP=1, then channel B with LOOP=0 -> second sequence writes (12,0x01) and triggers at address 10.
REQ-037 Push 5 requests back-to-back with FIFO_DEPTH=4 while busy -> READY low at count 4, fifth accepted after the first POP, all five triggers in order.
REQ-038 PCEN high one cycle in three -> identical write sequence, each write phase lasting 3 mclk cycles.
REQ-039 i_RST pulsed during the STROBE of the address-3 write -> DACS_n=1 in the same cycle, FIFO_CNT=0, no trigger write issued.
REQ-040 With K007232_VOICE_SEQ_VOL_EN, channel B request with VOL=0x7 -> write (13,0x07) precedes trigger (10,0x00).
